// File: rtl/mesi_isc_tb_coh_mon_pkg.sv
// Shared types and the combinational single-owner classifier for the TB coherence monitor.
// MESI encodings follow mesi_isc_tb_define.v; defaults are supplied if that file was not read first.
`ifndef MESI_ISC_TB_CPU_MESI_M
`define MESI_ISC_TB_CPU_MESI_M 4'b1001
`endif
`ifndef MESI_ISC_TB_CPU_MESI_E
`define MESI_ISC_TB_CPU_MESI_E 4'b0101
`endif
`ifndef MESI_ISC_TB_CPU_MESI_S
`define MESI_ISC_TB_CPU_MESI_S 4'b0011
`endif
`ifndef MESI_ISC_TB_CPU_MESI_I
`define MESI_ISC_TB_CPU_MESI_I 4'b0000
`endif

package mesi_isc_tb_coh_mon_pkg;

    localparam logic [3:0] MESI_M = `MESI_ISC_TB_CPU_MESI_M;
    localparam logic [3:0] MESI_E = `MESI_ISC_TB_CPU_MESI_E;
    localparam logic [3:0] MESI_S = `MESI_ISC_TB_CPU_MESI_S;
    localparam logic [3:0] MESI_I = `MESI_ISC_TB_CPU_MESI_I;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PEND  = 2'd2,
        ST_ERR   = 2'd3
    } mon_state_t;

    localparam logic [1:0] KIND_NONE    = 2'd0;
    localparam logic [1:0] KIND_OWNER   = 2'd1;
    localparam logic [1:0] KIND_ILLEGAL = 2'd2;

    function automatic logic is_mesi(input logic [3:0] s);
        return (s == MESI_M) || (s == MESI_E) || (s == MESI_S) || (s == MESI_I);
    endfunction

    // Returns {kind, cpu}. Scanning from CPU3 down leaves the lowest index in each capture.
    function automatic logic [3:0] classify(input logic [3:0] s0, input logic [3:0] s1,
                                            input logic [3:0] s2, input logic [3:0] s3);
        logic [3:0] st [4];
        logic       any_ill;
        logic       any_own;
        logic [1:0] ill_cpu;
        logic [1:0] own_cpu;
        logic [2:0] n_active;
        st[0]    = s0;
        st[1]    = s1;
        st[2]    = s2;
        st[3]    = s3;
        any_ill  = 1'b0;
        any_own  = 1'b0;
        ill_cpu  = 2'd0;
        own_cpu  = 2'd0;
        n_active = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!is_mesi(st[i])) begin
                any_ill = 1'b1;
                ill_cpu = 2'(i);
            end
            if ((st[i] == MESI_M) || (st[i] == MESI_E)) begin
                any_own = 1'b1;
                own_cpu = 2'(i);
            end
            if (st[i] != MESI_I) begin
                n_active = n_active + 3'd1;
            end
        end
        // An owner plus any other non-I line means at least two active lines.
        if (any_ill) begin
            return {KIND_ILLEGAL, ill_cpu};
        end
        if (any_own && (n_active >= 3'd2)) begin
            return {KIND_OWNER, own_cpu};
        end
        return {KIND_NONE, 2'd0};
    endfunction

endpackage

// File: rtl/mesi_isc_tb_coh_monitor_xcnt.sv
// Per-CPU state-transition counter: previous-sample register plus wrapping counter.
// Only instantiated when MESI_ISC_TB_COH_MON_XCNT_EN is defined.
module mesi_isc_tb_coh_xcnt
    import mesi_isc_tb_coh_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       cache_state,
    output logic [CNT_W-1:0] xcnt
);

    logic [3:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= MESI_I;
            xcnt   <= '0;
        end else if (en) begin
            prev_q <= cache_state;
            if (cache_state != prev_q) begin
                xcnt <= xcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mesi_isc_tb_coh_monitor.sv
// Coherence monitor: filtered single-owner check over four TB CPU line states with a sticky,
// acknowledgeable first-error record. Optional transition counters: MESI_ISC_TB_COH_MON_XCNT_EN.
module mesi_isc_tb_coh_monitor
    import mesi_isc_tb_coh_mon_pkg::*;
#(
    parameter int GRACE = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_en,
    input  logic [3:0]       cache_state_cpu0,
    input  logic [3:0]       cache_state_cpu1,
    input  logic [3:0]       cache_state_cpu2,
    input  logic [3:0]       cache_state_cpu3,
    input  logic             err_ack,
    output logic             err_flag,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_err_cpu,
    output logic [1:0]       first_err_kind,
    output logic [31:0]      first_err_cycle,
    output logic [31:0]      cycle_cnt,
    output logic [CNT_W-1:0] xcnt_cpu0,
    output logic [CNT_W-1:0] xcnt_cpu1,
    output logic [CNT_W-1:0] xcnt_cpu2,
    output logic [CNT_W-1:0] xcnt_cpu3,
    output mon_state_t       dbg_state
);

    localparam logic [3:0] GRACE_W   = 4'(GRACE);
    localparam logic       GRACE_ONE = (GRACE == 1);

    logic [3:0]  cls;
    logic [1:0]  cur_kind;
    logic [1:0]  cur_cpu;
    logic        viol;

    mon_state_t  state_q;
    mon_state_t  state_d;
    logic [3:0]  pers_q;
    logic [3:0]  pers_d;
    logic        latch_start;
    logic        enter_err;

    logic [31:0] start_cycle_q;
    logic [1:0]  start_kind_q;
    logic [1:0]  start_cpu_q;
    logic [31:0] cap_cycle;
    logic [1:0]  cap_kind;
    logic [1:0]  cap_cpu;

    assign cls      = classify(cache_state_cpu0, cache_state_cpu1,
                               cache_state_cpu2, cache_state_cpu3);
    assign cur_kind = cls[3:2];
    assign cur_cpu  = cls[1:0];
    assign viol     = (cur_kind != KIND_NONE);

    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        pers_d      = pers_q;
        latch_start = 1'b0;
        enter_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mon_en) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!mon_en) begin
                    state_d = ST_IDLE;
                    pers_d  = 4'd0;
                end else if (viol) begin
                    latch_start = 1'b1;
                    if (GRACE_ONE) begin
                        state_d   = ST_ERR;
                        enter_err = 1'b1;
                        pers_d    = 4'd0;
                    end else begin
                        state_d = ST_PEND;
                        pers_d  = 4'd1;
                    end
                end
            end
            ST_PEND: begin
                if (!mon_en) begin
                    state_d = ST_IDLE;
                    pers_d  = 4'd0;
                end else if (viol) begin
                    if ((pers_q + 4'd1) == GRACE_W) begin
                        state_d   = ST_ERR;
                        enter_err = 1'b1;
                        pers_d    = 4'd0;
                    end else begin
                        pers_d = pers_q + 4'd1;
                    end
                end else begin
                    state_d = ST_ARMED;
                    pers_d  = 4'd0;
                end
            end
            ST_ERR: begin
                // Ack wins over a concurrent violation; it is re-evaluated from ARMED.
                if (err_ack) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pers_d  = 4'd0;
            end
        endcase
    end

    // With GRACE=1 the episode starts and ends on the same sample, so bypass the latch.
    always_comb begin
        cap_cycle = start_cycle_q;
        cap_kind  = start_kind_q;
        cap_cpu   = start_cpu_q;
        if (state_q == ST_ARMED) begin
            cap_cycle = cycle_cnt;
            cap_kind  = cur_kind;
            cap_cpu   = cur_cpu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pers_q        <= 4'd0;
            start_cycle_q <= 32'd0;
            start_kind_q  <= KIND_NONE;
            start_cpu_q   <= 2'd0;
            cycle_cnt     <= 32'd0;
            err_flag      <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pers_q    <= pers_d;
            err_flag  <= (state_d == ST_ERR);
            err_pulse <= enter_err;
            if (mon_en) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (latch_start) begin
                start_cycle_q <= cycle_cnt;
                start_kind_q  <= cur_kind;
                start_cpu_q   <= cur_cpu;
            end
        end
    end

    // Only the first episode since reset is recorded; later ones only bump the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count       <= '0;
            first_err_cpu   <= 2'd0;
            first_err_kind  <= KIND_NONE;
            first_err_cycle <= 32'd0;
        end else if (enter_err) begin
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (err_count == '0) begin
                first_err_cpu   <= cap_cpu;
                first_err_kind  <= cap_kind;
                first_err_cycle <= cap_cycle;
            end
        end
    end

`ifdef MESI_ISC_TB_COH_MON_XCNT_EN
    mesi_isc_tb_coh_xcnt #(.CNT_W(CNT_W)) u_xcnt0 (
        .clk(clk), .rst(rst), .en(mon_en), .cache_state(cache_state_cpu0), .xcnt(xcnt_cpu0)
    );
    mesi_isc_tb_coh_xcnt #(.CNT_W(CNT_W)) u_xcnt1 (
        .clk(clk), .rst(rst), .en(mon_en), .cache_state(cache_state_cpu1), .xcnt(xcnt_cpu1)
    );
    mesi_isc_tb_coh_xcnt #(.CNT_W(CNT_W)) u_xcnt2 (
        .clk(clk), .rst(rst), .en(mon_en), .cache_state(cache_state_cpu2), .xcnt(xcnt_cpu2)
    );
    mesi_isc_tb_coh_xcnt #(.CNT_W(CNT_W)) u_xcnt3 (
        .clk(clk), .rst(rst), .en(mon_en), .cache_state(cache_state_cpu3), .xcnt(xcnt_cpu3)
    );
`else
    assign xcnt_cpu0 = '0;
    assign xcnt_cpu1 = '0;
    assign xcnt_cpu2 = '0;
    assign xcnt_cpu3 = '0;
`endif

endmodule

// File: tb/tb_mesi_isc_tb_coh_monitor.sv
// Bench for mesi_isc_tb_coh_monitor (GRACE=2): classification table, cycle-by-cycle episode
// table checked through an expected-value queue, and hand sequences for reset and counters.
module tb_mesi_isc_tb_coh_monitor;
    import mesi_isc_tb_coh_mon_pkg::*;

    localparam int CNT_W = 16;
    localparam int EXP_W = 52;
`ifdef MESI_ISC_TB_COH_MON_XCNT_EN
    localparam int XC0_EXP = 3;
`else
    localparam int XC0_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             mon_en;
    logic [3:0]       cs0, cs1, cs2, cs3;
    logic             err_ack;
    logic             err_flag;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       first_err_cpu;
    logic [1:0]       first_err_kind;
    logic [31:0]      first_err_cycle;
    logic [31:0]      cycle_cnt;
    logic [CNT_W-1:0] xcnt_cpu0, xcnt_cpu1, xcnt_cpu2, xcnt_cpu3;
    mon_state_t       dbg_state;

    mesi_isc_tb_coh_monitor #(.GRACE(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mon_en(mon_en),
        .cache_state_cpu0(cs0), .cache_state_cpu1(cs1),
        .cache_state_cpu2(cs2), .cache_state_cpu3(cs3),
        .err_ack(err_ack), .err_flag(err_flag), .err_pulse(err_pulse),
        .err_count(err_count), .first_err_cpu(first_err_cpu),
        .first_err_kind(first_err_kind), .first_err_cycle(first_err_cycle),
        .cycle_cnt(cycle_cnt),
        .xcnt_cpu0(xcnt_cpu0), .xcnt_cpu1(xcnt_cpu1),
        .xcnt_cpu2(xcnt_cpu2), .xcnt_cpu3(xcnt_cpu3),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cyc;
    logic [EXP_W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic en, input logic ack);
        cs0     = a;
        cs1     = b;
        cs2     = c;
        cs3     = d;
        mon_en  = en;
        err_ack = ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(MESI_I, MESI_I, MESI_I, MESI_I, 1'b0, 1'b0);
        tick();
        tick();
        rst     = 1'b0;
        exp_cyc = 32'd0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus tables ----------------
    typedef struct {
        logic [3:0] s0, s1, s2, s3;
        logic [1:0] kind;
        logic [1:0] cpu;
    } cls_vec_t;

    typedef struct {
        logic [3:0]  s0, s1, s2, s3;
        logic        en;
        logic        ack;
        int          rep;
        logic        flag;
        logic        pulse;
        logic [1:0]  st;
        logic [15:0] cnt;
    } seq_vec_t;

    localparam int NCLS = 12;
    localparam int NSEQ = 20;
    cls_vec_t cls_tab [NCLS];
    seq_vec_t seq_tab [NSEQ];

    initial begin
        logic [EXP_W-1:0] exp_word;
        logic [EXP_W-1:0] act_word;

        cls_tab[0]  = '{MESI_I, MESI_I, MESI_I, MESI_I, KIND_NONE,    2'd0};
        cls_tab[1]  = '{MESI_E, MESI_I, MESI_I, MESI_I, KIND_NONE,    2'd0};
        cls_tab[2]  = '{MESI_M, MESI_I, MESI_I, MESI_I, KIND_NONE,    2'd0};
        cls_tab[3]  = '{MESI_S, MESI_S, MESI_S, MESI_S, KIND_NONE,    2'd0};
        cls_tab[4]  = '{MESI_I, MESI_I, MESI_M, MESI_S, KIND_OWNER,   2'd2};
        cls_tab[5]  = '{MESI_S, MESI_I, MESI_I, MESI_E, KIND_OWNER,   2'd3};
        cls_tab[6]  = '{MESI_E, MESI_M, MESI_I, MESI_I, KIND_OWNER,   2'd0};
        cls_tab[7]  = '{MESI_I, MESI_S, MESI_E, MESI_M, KIND_OWNER,   2'd2};
        cls_tab[8]  = '{MESI_I, MESI_I, MESI_I, 4'h1,   KIND_ILLEGAL, 2'd3};
        cls_tab[9]  = '{MESI_M, MESI_S, 4'h7,   4'hF,   KIND_ILLEGAL, 2'd2};
        cls_tab[10] = '{4'h8,   MESI_I, MESI_I, MESI_I, KIND_ILLEGAL, 2'd0};
        cls_tab[11] = '{MESI_I, 4'hC,   MESI_I, 4'h2,   KIND_ILLEGAL, 2'd1};

        //                 s0      s1      s2      s3    en    ack  rep flag pulse state     cnt
        seq_tab[0]  = '{MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0, 38, 1'b0, 1'b0, ST_ARMED, 16'd0};
        seq_tab[1]  = '{MESI_S, MESI_I, MESI_M, MESI_I, 1'b1, 1'b0, 1,  1'b0, 1'b0, ST_PEND,  16'd0};
        seq_tab[2]  = '{MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0, 1,  1'b0, 1'b0, ST_ARMED, 16'd0};
        seq_tab[3]  = '{MESI_I, MESI_E, MESI_I, MESI_S, 1'b1, 1'b0, 1,  1'b0, 1'b0, ST_PEND,  16'd0};
        seq_tab[4]  = '{MESI_I, MESI_E, MESI_I, MESI_S, 1'b1, 1'b0, 1,  1'b1, 1'b1, ST_ERR,   16'd1};
        seq_tab[5]  = '{MESI_I, MESI_E, MESI_I, MESI_S, 1'b1, 1'b0, 1,  1'b1, 1'b0, ST_ERR,   16'd1};
        seq_tab[6]  = '{4'hF,   MESI_E, MESI_I, MESI_S, 1'b1, 1'b0, 5,  1'b1, 1'b0, ST_ERR,   16'd1};
        seq_tab[7]  = '{4'hF,   MESI_E, MESI_I, MESI_S, 1'b1, 1'b1, 1,  1'b0, 1'b0, ST_ARMED, 16'd1};
        seq_tab[8]  = '{4'hF,   MESI_E, MESI_I, MESI_S, 1'b1, 1'b0, 1,  1'b0, 1'b0, ST_PEND,  16'd1};
        seq_tab[9]  = '{4'hF,   MESI_E, MESI_I, MESI_S, 1'b1, 1'b0, 1,  1'b1, 1'b1, ST_ERR,   16'd2};
        seq_tab[10] = '{MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b1, 1,  1'b0, 1'b0, ST_ARMED, 16'd2};
        seq_tab[11] = '{MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b1, 2,  1'b0, 1'b0, ST_ARMED, 16'd2};
        seq_tab[12] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b1, 1'b1, 1,  1'b0, 1'b0, ST_PEND,  16'd2};
        seq_tab[13] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b0, 1'b0, 1,  1'b0, 1'b0, ST_IDLE,  16'd2};
        seq_tab[14] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b0, 1'b0, 3,  1'b0, 1'b0, ST_IDLE,  16'd2};
        seq_tab[15] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b1, 1'b0, 1,  1'b0, 1'b0, ST_ARMED, 16'd2};
        seq_tab[16] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b1, 1'b0, 1,  1'b0, 1'b0, ST_PEND,  16'd2};
        seq_tab[17] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b1, 1'b0, 1,  1'b1, 1'b1, ST_ERR,   16'd3};
        seq_tab[18] = '{MESI_I, MESI_M, MESI_S, MESI_I, 1'b0, 1'b0, 2,  1'b1, 1'b0, ST_ERR,   16'd3};
        seq_tab[19] = '{MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b1, 1,  1'b0, 1'b0, ST_ARMED, 16'd3};

        // ---- reset state ----
        do_reset();
        check("rst_state",   64'(dbg_state),       64'(ST_IDLE));
        check("rst_flag",    64'(err_flag),        64'd0);
        check("rst_pulse",   64'(err_pulse),       64'd0);
        check("rst_count",   64'(err_count),       64'd0);
        check("rst_first",   {28'd0, first_err_cpu, first_err_kind, first_err_cycle}, 64'd0);
        check("rst_cycle",   64'(cycle_cnt),       64'd0);
        check("rst_xcnt",    {xcnt_cpu0, xcnt_cpu1, xcnt_cpu2, xcnt_cpu3}, 64'd0);

        // ---- quiet run: 100 enabled samples ----
        drive(MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0);
        repeat (100) tick();
        check("quiet_cycle", 64'(cycle_cnt), 64'd100);
        check("quiet_flag",  64'(err_flag),  64'd0);
        check("quiet_count", 64'(err_count), 64'd0);
        check("quiet_state", 64'(dbg_state), 64'(ST_ARMED));

        // ---- classification table ----
        for (int i = 0; i < NCLS; i++) begin
            do_reset();
            drive(MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0);
            tick();
            drive(cls_tab[i].s0, cls_tab[i].s1, cls_tab[i].s2, cls_tab[i].s3, 1'b1, 1'b0);
            tick();
            tick();
            check($sformatf("cls[%0d]_flag", i), 64'(err_flag), 64'(cls_tab[i].kind != KIND_NONE));
            check($sformatf("cls[%0d]_kind", i), 64'(first_err_kind), 64'(cls_tab[i].kind));
            check($sformatf("cls[%0d]_cpu", i),  64'(first_err_cpu),  64'(cls_tab[i].cpu));
            check($sformatf("cls[%0d]_cyc", i),  64'(first_err_cycle),
                  (cls_tab[i].kind != KIND_NONE) ? 64'd1 : 64'd0);
        end

        // ---- episode sequence through the expected queue ----
        do_reset();
        for (int i = 0; i < NSEQ; i++) begin
            for (int r = 0; r < seq_tab[i].rep; r++) begin
                drive(seq_tab[i].s0, seq_tab[i].s1, seq_tab[i].s2, seq_tab[i].s3,
                      seq_tab[i].en, seq_tab[i].ack);
                if (seq_tab[i].en) exp_cyc = exp_cyc + 32'd1;
                exp_q.push_back({seq_tab[i].flag, seq_tab[i].pulse, seq_tab[i].st,
                                 seq_tab[i].cnt, exp_cyc});
                tick();
                exp_word = exp_q.pop_front();
                act_word = {err_flag, err_pulse, dbg_state, err_count, cycle_cnt};
                check($sformatf("seq[%0d.%0d]", i, r), 64'(act_word), 64'(exp_word));
            end
        end
        check("cap_cpu",   64'(first_err_cpu),   64'd1);
        check("cap_kind",  64'(first_err_kind),  64'(KIND_OWNER));
        check("cap_cycle", 64'(first_err_cycle), 64'd40);

        // ---- reset in ERR overrides ack ----
        drive(MESI_I, MESI_M, MESI_S, MESI_I, 1'b1, 1'b0);
        tick();
        tick();
        check("pre_rst_flag",  64'(err_flag),  64'd1);
        check("pre_rst_count", 64'(err_count), 64'd4);
        rst     = 1'b1;
        err_ack = 1'b1;
        tick();
        check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("mid_rst_outs",  {err_flag, err_pulse, 14'd0, err_count, cycle_cnt}, 64'd0);
        check("mid_rst_first", {28'd0, first_err_cpu, first_err_kind, first_err_cycle}, 64'd0);
        rst = 1'b0;

        // ---- transition counters: CPU0 I->S->M->I ----
        do_reset();
        drive(MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0);
        tick();
        drive(MESI_S, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0);
        tick();
        drive(MESI_M, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0);
        tick();
        drive(MESI_I, MESI_I, MESI_I, MESI_I, 1'b1, 1'b0);
        tick();
        check("xcnt0",      64'(xcnt_cpu0), 64'(XC0_EXP));
        check("xcnt123",    {16'd0, xcnt_cpu1, xcnt_cpu2, xcnt_cpu3}, 64'd0);
        check("xcnt_flag",  64'(err_flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mesi_isc_tb_coh_monitor.md
# mesi_isc_tb_coh_monitor

Cycle-accurate coherence monitor bound into `mesi_isc_tb`, downstream of the four TB CPU models (`mesi_isc_tb_cpu0..3`). It consumes their per-line `cache_state` outputs every clock and runs a filtered single-owner check. It captures the first offending episode and counts episodes, giving the bench a sticky, acknowledgeable error record alongside the immediate SVA checks.

## Interface
Parameters:
- `GRACE`, 2: consecutive violating samples required before an episode is flagged; legal range 1..15.
- `CNT_W`, 16: width of `err_count` and the per-CPU transition counters.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `mon_en`  in  1  monitor enable.
- `cache_state_cpu0..3`  in  4 each  MESI state of CPU 0..3; encodings are the `MESI_ISC_TB_CPU_MESI_M/E/S/I` macros.
- `err_ack`  in  1  clears the ERR state.
- `err_flag`  out  1  high while in ERR.
- `err_pulse`  out  1  one-cycle strobe on entry to ERR.
- `err_count`  out  CNT_W  flagged episodes, saturating.
- `first_err_cpu`  out  2  offending CPU of the captured episode.
- `first_err_kind`  out  2  0 none, 1 owner-with-copy, 2 illegal encoding.
- `first_err_cycle`  out  32  `cycle_cnt` at the first sample of the captured episode.
- `cycle_cnt`  out  32  free-running sample counter.
- `xcnt_cpu0..3`  out  CNT_W each  per-CPU state-transition counts.

## Operation
- Reset values: all outputs 0, FSM in IDLE, persistence counter 0.
- `cycle_cnt` increments on every edge with `mon_en`=1. It wraps at 2^32 and is frozen while `mon_en`=0.
- Classification is combinational on current inputs. An illegal encoding means a value that is not M/E/S/I.
- Kind priority: illegal (2) over owner-with-copy (1).
- Owner-with-copy: any CPU in M or E while at least one other CPU is not in I.
- Reported CPU: the lowest-index CPU with an illegal encoding; for kind 1, the lowest-index CPU in M/E.
- FSM states:
  - IDLE: go to ARMED when `mon_en`=1.
  - ARMED: on a violation, latch start cycle, kind and CPU. If `GRACE`=1, go to ERR; otherwise go to PEND with persistence count 1.
  - PEND: a violation increments the count, and reaching `GRACE` moves to ERR. No violation returns to ARMED and clears the count.
  - ERR: hold until `err_ack`=1, then go to ARMED.
- Kind or CPU may change during PEND. Only the values latched at the first sample are reported.
- On entry to ERR:
  - `err_pulse`=1 for one cycle.
  - `err_count`+1, saturating at all-ones.
  - `first_*` are overwritten only if `err_count` was 0 before the increment. They always hold the first episode since reset.
- Further violations while in ERR are neither counted nor captured.
- `mon_en`=0 forces ARMED/PEND to IDLE and clears the persistence count. ERR is retained until acknowledged.
- `err_ack` outside ERR is ignored. `err_ack` together with a violation in ERR: the ack wins. Next state is ARMED, and the violation is re-evaluated from the next sample.
- `rst` mid-episode: everything returns to reset values at that edge, and `rst` overrides `err_ack`.

## Timing
- Inputs are sampled at posedge t. All outputs are registered.
- Episode with violating samples t..t+GRACE-1: `err_flag`/`err_pulse` go high after edge t+GRACE-1. `first_err_cycle` = `cycle_cnt` value sampled at t.
- `err_ack` sampled at edge a: `err_flag` is low after edge a, and a new episode can begin at sample a+1.
- `err_pulse` is never high in two consecutive cycles.

## Configuration
- `MESI_ISC_TB_COH_MON_XCNT_EN` defined:
  - each `xcnt_cpuN` increments on every enabled edge where `cache_state_cpuN` differs from its previous registered sample;
  - counters wrap;
  - the previous-sample register resets to I.
- Not defined: the `xcnt_cpuN` ports remain and are tied to 0, and no sample registers are built.

## Structure
- Package `mesi_isc_tb_coh_mon_pkg` holds:
  - the FSM state enum (IDLE, ARMED, PEND, ERR);
  - the kind localparams (KIND_NONE/OWNER/ILLEGAL);
  - function `classify`, which takes four states and returns `{kind, cpu}`.
- MESI encodings come from `mesi_isc_tb_define.v`.
- Sub-module `mesi_isc_tb_coh_xcnt`: one per CPU. It contains a previous-state register and a transition counter, and is instantiated only under the macro.

## Test plan
- Reset, `mon_en`=1, all CPUs I for 100 cycles -> `err_flag`=0, `err_count`=0, `cycle_cnt`=100.
- CPU2=M, CPU0=S for exactly 1 sample with `GRACE`=2 -> no flag, FSM back in ARMED, `err_count`=0.
- CPU1=E, CPU3=S starting at `cycle_cnt`=40 for 3 samples:
  - `err_pulse` after sample 41;
  - `first_err_cpu`=1, `first_err_kind`=1, `first_err_cycle`=40, `err_count`=1.
- While in ERR, CPU0=4'hF for 5 cycles -> `err_count` stays 1 and the capture is unchanged. Then `err_ack` with the violation still present -> ARMED, then a new episode, and `err_count`=2 with `first_*` unchanged.
- `mon_en` dropped during PEND -> IDLE and `cycle_cnt` frozen. Re-enable with the violation present -> the full `GRACE` count restarts.
- With the macro defined, CPU0 toggles I->S->M->I -> `xcnt_cpu0`=3 and other counters 0. Without the macro, all `xcnt` outputs are 0.
